// File: rtl/matrix_result_collector.sv
// Result collector for the sequential FP32 matrix multiplier.
// Captures (z, i, j) results into an MxM store over the z_stb/z_ack
// handshake, then streams the matrix row-major over a valid/ready port.
module matrix_result_collector #(
    parameter  int M  = 4,
    parameter  int DW = 32,
    localparam int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] z_in,
    input  logic [IW-1:0] z_i,
    input  logic [IW-1:0] z_j,
    input  logic          z_stb,
    output logic          z_ack,
    input  logic          mul_done,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_row,
    output logic [IW-1:0] out_col,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          idx_err,
    output logic          incomplete
);

    localparam int              N      = M * M;
    localparam int              PW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW:0]     M_IW   = (IW + 1)'(M);
    localparam logic [PW-1:0]   M_PW   = PW'(M);
    localparam logic [PW-1:0]   LAST_P = PW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ACK,
        S_DRAIN
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [DW-1:0]   mem [N];
    logic [N-1:0]    written;
    logic            done_pend;
    logic [PW-1:0]   rd_ptr;

    logic            accept;
    logic            idx_ok;
    logic [PW-1:0]   wr_idx;
    logic            beat;
    logic            load;
    logic [PW-1:0]   ld_idx;
    logic            drain_entry;

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next is defaulted first so no path through this block can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (start) state_next = S_COLLECT;
            S_COLLECT: begin
                if (z_stb)         state_next = S_ACK;
                else if (mul_done) state_next = S_DRAIN;
            end
            S_ACK:     state_next = (done_pend || mul_done) ? S_DRAIN : S_COLLECT;
            S_DRAIN:   if (out_valid && out_ready && out_last) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Output and control decode: accept/write index, drain load strobe.
    always_comb begin
        busy        = (state != S_IDLE);
        accept      = (state == S_COLLECT) && z_stb;
        idx_ok      = ({1'b0, z_i} < M_IW) && ({1'b0, z_j} < M_IW);
        wr_idx      = PW'(z_i) * M_PW + PW'(z_j);
        beat        = out_valid && out_ready;
        // A new element is loaded on the first drain cycle and after every non-final transfer.
        load        = (state == S_DRAIN) && (!out_valid || (out_ready && !out_last));
        ld_idx      = out_valid ? rd_ptr + PW'(1) : rd_ptr;
        drain_entry = (state != S_DRAIN) && (state_next == S_DRAIN);
    end

    // Result store write port.
    // NOTE: the store has no reset; the written bitmap masks stale contents on drain.
    always_ff @(posedge clk) begin
        if (accept && idx_ok) mem[wr_idx] <= z_in;
    end

    // Handshake, bitmap, sticky flags and registered drain outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_ack      <= 1'b0;
            written    <= '0;
            done_pend  <= 1'b0;
            idx_err    <= 1'b0;
            incomplete <= 1'b0;
            rd_ptr     <= '0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            z_ack <= accept;

            if (state == S_IDLE && start) begin
                written    <= '0;
                idx_err    <= 1'b0;
                incomplete <= 1'b0;
                done_pend  <= 1'b0;
            end

            if (accept) begin
                if (idx_ok) written[wr_idx] <= 1'b1;
                else        idx_err         <= 1'b1;
                if (mul_done) done_pend <= 1'b1;
            end

            if (drain_entry) begin
                incomplete <= ~(&written);
                rd_ptr     <= '0;
            end

            if (load) begin
                rd_ptr    <= ld_idx;
                out_data  <= written[ld_idx] ? mem[ld_idx] : '0;
                out_row   <= IW'(ld_idx / M_PW);
                out_col   <= IW'(ld_idx % M_PW);
                out_last  <= (ld_idx == LAST_P);
                out_valid <= 1'b1;
            end else if (beat && out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_result_collector.sv
// Self-checking bench for matrix_result_collector: randomized collect/drain
// traffic checked against a plain-array model of the result matrix, plus an
// M=3 instance for out-of-range index handling.
module tb_matrix_result_collector;

    localparam int M  = 4;
    localparam int N  = M * M;
    localparam int DW = 32;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, z_stb, mul_done, out_ready;
    logic [DW-1:0] z_in;
    logic [IW-1:0] z_i, z_j;
    logic          z_ack, out_valid, out_last, busy, idx_err, incomplete;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_row, out_col;

    logic          m3_start, m3_z_stb, m3_mul_done, m3_out_ready;
    logic [DW-1:0] m3_z_in;
    logic [1:0]    m3_z_i, m3_z_j;
    logic          m3_z_ack, m3_out_valid, m3_out_last, m3_busy, m3_idx_err, m3_incomplete;
    logic [DW-1:0] m3_out_data;
    logic [1:0]    m3_out_row, m3_out_col;

    matrix_result_collector #(.M(M), .DW(DW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .z_in(z_in), .z_i(z_i), .z_j(z_j),
        .z_stb(z_stb), .z_ack(z_ack), .mul_done(mul_done), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .idx_err(idx_err), .incomplete(incomplete)
    );

    matrix_result_collector #(.M(3), .DW(DW)) u_dut3 (
        .clk(clk), .rst(rst), .start(m3_start), .z_in(m3_z_in), .z_i(m3_z_i), .z_j(m3_z_j),
        .z_stb(m3_z_stb), .z_ack(m3_z_ack), .mul_done(m3_mul_done), .out_data(m3_out_data),
        .out_row(m3_out_row), .out_col(m3_out_col), .out_valid(m3_out_valid),
        .out_ready(m3_out_ready), .out_last(m3_out_last), .busy(m3_busy),
        .idx_err(m3_idx_err), .incomplete(m3_incomplete)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mv [N];
    bit          mw [N];
    logic [63:0] exp_q [$];
    int          beats_seen = 0;
    logic [31:0] got_data [N];
    logic        prev_ack = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_beat(input logic [31:0] d, input int p);
        return 64'({d, 2'(p / M), 2'(p % M), 1'(p == N - 1)});
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = '0;
            mw[i] = 1'b0;
        end
    endtask

    task automatic build_expect();
        exp_q.delete();
        for (int p = 0; p < N; p++) exp_q.push_back(pack_beat(mw[p] ? mv[p] : 32'h0, p));
    endtask

    function automatic bit model_incomplete();
        for (int p = 0; p < N; p++) if (!mw[p]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_start();
        model_clear();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_flags", 64'({idx_err, incomplete}), 64'(0));
    endtask

    task automatic send(input int r, input int c, input logic [31:0] v);
        bit got = 1'b0;
        @(negedge clk);
        z_stb = 1'b1; z_i = IW'(r); z_j = IW'(c); z_in = v;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (z_ack) begin got = 1'b1; break; end
        end
        z_stb = 1'b0;
        check("send_ack", 64'(got), 64'(1));
        if (got) begin mv[r*M+c] = v; mw[r*M+c] = 1'b1; end
    endtask

    // Drain the matrix; stop_after>0 abandons the drain after that many beats.
    task automatic do_drain(input bit rand_ready, input int stop_after, input bit raise_done);
        int  stop;
        int  k_end;
        bit  exp_inc;
        stop    = (stop_after > 0) ? stop_after : N;
        exp_inc = model_incomplete();
        k_end   = -1;
        build_expect();
        beats_seen = 0;
        out_ready  = 1'b1;
        if (raise_done) begin
            @(negedge clk); mul_done = 1'b1;
            @(posedge clk); #1 mul_done = 1'b0;
            check("drain_lat0_valid", 64'(out_valid), 64'(0));
            check("drain_lat0_busy", 64'(busy), 64'(1));
            @(posedge clk); #1;
            check("drain_lat1_valid", 64'(out_valid), 64'(1));
        end
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (beats_seen >= stop) begin k_end = k; break; end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("drain_beats", 64'(beats_seen), 64'(stop));
        if (stop_after == 0) begin
            if (raise_done && !rand_ready) check("drain_throughput", 64'(k_end), 64'(N - 1));
            check("drain_idle", 64'({busy, out_valid, out_last}), 64'(0));
            check("drain_incomplete", 64'(incomplete), 64'(exp_inc));
            check("drain_idx_err", 64'(idx_err), 64'(0));
            check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        end
        out_ready = 1'b0;
    endtask

    task automatic m3_send(input int r, input int c, input logic [31:0] v);
        bit got = 1'b0;
        @(negedge clk);
        m3_z_stb = 1'b1; m3_z_i = 2'(r); m3_z_j = 2'(c); m3_z_in = v;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (m3_z_ack) begin got = 1'b1; break; end
        end
        m3_z_stb = 1'b0;
        check("m3_send_ack", 64'(got), 64'(1));
    endtask

    // Stream compare: every presented beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            if (z_ack) check("z_ack_width", 64'(prev_ack), 64'(0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("beat_expected", 64'(exp_q.size()), 64'(1));
                end else begin
                    check("beat", 64'({out_data, out_row, out_col, out_last}), exp_q[0]);
                    if (out_ready) begin
                        if (beats_seen < N) got_data[beats_seen] = out_data;
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
        end
        prev_ack = z_ack;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          order [N];
        int          acks;
        int          m3_beats;
        logic [31:0] v;
        logic [31:0] v2;

        rst = 1'b0; start = 1'b0; z_stb = 1'b0; mul_done = 1'b0; out_ready = 1'b0;
        z_in = '0; z_i = '0; z_j = '0;
        m3_start = 1'b0; m3_z_stb = 1'b0; m3_mul_done = 1'b0; m3_out_ready = 1'b0;
        m3_z_in = '0; m3_z_i = '0; m3_z_j = '0;
        model_clear();

        // Reset values
        #23;
        check("rst_flags", 64'({z_ack, out_valid, out_last, busy, idx_err, incomplete}), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_rowcol", 64'({out_row, out_col}), 64'(0));
        check("rst_m3", 64'({m3_z_ack, m3_out_valid, m3_busy, m3_idx_err, m3_incomplete}), 64'(0));
        @(posedge clk); #1 rst = 1'b1;

        // Full matrix, row-major writes, known values
        do_start();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) send(r, c, 32'h3F80_0000 + 32'(r * 4 + c));
        do_drain(1'b0, 0, 1'b1);
        check("t1_first_val", 64'(got_data[0]), 64'(32'h3F80_0000));
        check("t1_last_val", 64'(got_data[15]), 64'(32'h3F80_000F));
        check("t1_incomplete", 64'(incomplete), 64'(0));

        // Overwrites to (1,2) with random background, stalling consumer
        do_start();
        for (int k = 0; k < 6; k++) begin
            int p;
            p = $urandom_range(0, N - 1);
            if (p != 6) send(p / M, p % M, $urandom);
        end
        send(1, 2, 32'h3F80_0000);
        send(1, 2, 32'h4000_0000);
        send(1, 2, 32'h4040_0000);
        send(1, 2, 32'h4080_0000);
        do_drain(1'b1, 0, 1'b1);
        check("t2_overwrite", 64'(got_data[6]), 64'(32'h4080_0000));

        // z_stb held high for 10 cycles
        do_start();
        v = $urandom;
        @(negedge clk); z_stb = 1'b1; z_i = 2'd2; z_j = 2'd3; z_in = v;
        acks = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (z_ack) acks++;
        end
        z_stb = 1'b0;
        check("t3_ack_count", 64'(acks), 64'(5));
        if (acks > 0) begin mv[11] = v; mw[11] = 1'b1; end
        do_drain(1'b0, 0, 1'b1);

        // Single element written
        do_start();
        send(0, 0, 32'h4000_0000);
        do_drain(1'b0, 0, 1'b1);
        check("t4_incomplete", 64'(incomplete), 64'(1));
        check("t4_val00", 64'(got_data[0]), 64'(32'h4000_0000));
        check("t4_val01", 64'(got_data[1]), 64'(0));

        // Random full matrix in random order, start mid-collect ignored, ready toggling
        do_start();
        for (int i = 0; i < N; i++) order[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int k = 0; k < N; k++) begin
            send(order[k] / M, order[k] % M, $urandom);
            if (k == 7) begin
                @(negedge clk); start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        do_drain(1'b1, 0, 1'b1);

        // mul_done coincident with the last z_stb
        do_start();
        for (int k = 0; k < 3; k++) send($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        @(posedge clk);
        v = $urandom;
        @(negedge clk); z_stb = 1'b1; z_i = 2'd3; z_j = 2'd1; z_in = v; mul_done = 1'b1;
        @(posedge clk); #1 z_stb = 1'b0; mul_done = 1'b0;
        check("t6_ack", 64'(z_ack), 64'(1));
        if (z_ack) begin mv[13] = v; mw[13] = 1'b1; end
        @(posedge clk); #1;
        check("t6_drain_entered", 64'({busy, out_valid}), 64'(2'b10));
        do_drain(1'b0, 0, 1'b0);
        check("t6_kept", 64'(got_data[13]), 64'(v));

        // z_stb in idle is ignored
        @(negedge clk); z_stb = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("t7_idle_no_ack", 64'({z_ack, busy}), 64'(0));
        end
        z_stb = 1'b0;

        // Reset mid-drain, then a fresh matrix
        do_start();
        for (int k = 0; k < 5; k++) send(k / M, k % M, $urandom);
        do_drain(1'b0, 5, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t8_rst_valid_busy", 64'({out_valid, busy, out_last}), 64'(0));
        check("t8_rst_data", 64'(out_data), 64'(0));
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        do_start();
        v = $urandom;
        send(3, 3, v);
        do_drain(1'b0, 0, 1'b1);
        check("t8_fresh_val", 64'(got_data[15]), 64'(v));

        // M=3 instance: out-of-range row is acked, flagged and not stored
        @(negedge clk); m3_start = 1'b1;
        @(posedge clk); #1 m3_start = 1'b0;
        check("m3_busy", 64'(m3_busy), 64'(1));
        m3_send(3, 0, $urandom);
        check("m3_idx_err", 64'(m3_idx_err), 64'(1));
        v2 = $urandom;
        m3_send(1, 1, v2);
        m3_out_ready = 1'b1;
        @(negedge clk); m3_mul_done = 1'b1;
        @(posedge clk); #1 m3_mul_done = 1'b0;
        m3_beats = 0;
        for (int k = 0; k < 40 && m3_beats < 9; k++) begin
            @(negedge clk);
            if (m3_out_valid) begin
                check("m3_beat", 64'({m3_out_data, m3_out_row, m3_out_col, m3_out_last}),
                      64'({((m3_beats == 4) ? v2 : 32'h0), 2'(m3_beats / 3), 2'(m3_beats % 3),
                           1'(m3_beats == 8)}));
                m3_beats++;
            end
        end
        check("m3_beat_count", 64'(m3_beats), 64'(9));
        @(posedge clk); #1;
        check("m3_end", 64'({m3_busy, m3_out_valid, m3_idx_err, m3_incomplete}), 64'(4'b0011));
        m3_out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
